// File: rtl/axis_tg_pkg.sv
// axis_tg_pkg: shared constants and helpers for the AXI-Stream traffic generator.
//   LOAD_LFSR_* : 16-bit injection LFSR geometry (taps 16,14,13,11)
//   DEST_LFSR_* : 64-bit destination LFSR geometry (taps 64,63,61,60)
//   fix_seed()  : maps an all-zero seed (LFSR lock-up state) to 1
package axis_tg_pkg;

    localparam int unsigned LOAD_LFSR_WIDTH = 16;
    localparam int unsigned DEST_LFSR_WIDTH = 64;

    // Tap masks: bit (n-1) set for tap n; feedback is the XOR of the masked state.
    localparam logic [LOAD_LFSR_WIDTH-1:0] LOAD_LFSR_TAPS = 16'hB400;
    localparam logic [DEST_LFSR_WIDTH-1:0] DEST_LFSR_TAPS = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] fix_seed(input logic [63:0] seed);
        return (seed == 64'd0) ? 64'd1 : seed;
    endfunction

endpackage

// File: rtl/axis_tg_lfsr.sv
// axis_tg_lfsr: Fibonacci LFSR shifting left, feedback entering bit 0.
//   clk   in  clock
//   rst_n in  synchronous active-low reset (reloads the fixed-up seed)
//   en    in  advance one step this cycle
//   value out low OUT_WIDTH bits of the current (pre-step) state
module axis_tg_lfsr
    import axis_tg_pkg::*;
#(
    parameter int unsigned       WIDTH     = 16,
    parameter int unsigned       OUT_WIDTH = 16,
    parameter logic [WIDTH-1:0]  TAPS      = WIDTH'(LOAD_LFSR_TAPS),
    parameter logic [WIDTH-1:0]  SEED      = WIDTH'(1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic [OUT_WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] SEED_FIX = WIDTH'(fix_seed(64'(SEED)));

    logic [WIDTH-1:0] state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEED_FIX;
        end else if (en) begin
            state_q <= {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        end
    end

    assign value = state_q[OUT_WIDTH-1:0];

endmodule

// File: rtl/axis_tg.sv
// axis_tg: random-injection AXI-Stream traffic generator with per-destination counters.
//   clk, rst_n          clock, synchronous active-low reset
//   load                injection threshold (probability load/65536 per active cycle)
//   num_packets         total packets to generate
//   start               level enable for new injections
//   ticks               free-running timestamp captured into tdata upper half
//   done                all num_packets accepted downstream (sticky until reset)
//   sent_packets        packed per-destination accepted counts, dest i at slice i
//   axis_out_*          AXI-Stream master, single-flit packets from a one-entry register
module axis_tg
    import axis_tg_pkg::*;
#(
    parameter logic [63:0]          DEST_SEED   = 64'h1,
    parameter logic [15:0]          LOAD_SEED   = 16'h1,
    parameter int unsigned          COUNT_WIDTH = 16,
    parameter int unsigned          TDATA_WIDTH = 32,
    parameter int unsigned          TDEST_WIDTH = 2,
    parameter int unsigned          TID_WIDTH   = 2,
    parameter logic [TID_WIDTH-1:0] TID         = '0
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [15:0]                               load,
    input  logic [COUNT_WIDTH-1:0]                    num_packets,
    input  logic                                      start,
    input  logic [TDATA_WIDTH/2-1:0]                  ticks,
    output logic                                      done,
    output logic [(2**TDEST_WIDTH)*COUNT_WIDTH-1:0]   sent_packets,
    output logic                                      axis_out_tvalid,
    input  logic                                      axis_out_tready,
    output logic [TDATA_WIDTH-1:0]                    axis_out_tdata,
    output logic                                      axis_out_tlast,
    output logic [TID_WIDTH-1:0]                      axis_out_tid,
    output logic [TDEST_WIDTH-1:0]                    axis_out_tdest
);

    localparam int                      NUM_DEST = 2**TDEST_WIDTH;
    localparam int unsigned             HALF     = TDATA_WIDTH / 2;
    localparam logic [COUNT_WIDTH-1:0]  CNT_ONE  = COUNT_WIDTH'(1);

    logic [LOAD_LFSR_WIDTH-1:0] load_state;
    logic [TDEST_WIDTH-1:0]     new_dest;

    logic active, inj_evt, hs, load_flit;

    logic [COUNT_WIDTH-1:0] backlog_q, backlog_inc;
    logic [COUNT_WIDTH-1:0] generated_q, total_q, total_d;
    logic [COUNT_WIDTH-1:0] cnt_q [NUM_DEST];
    logic [COUNT_WIDTH-1:0] cnt_d [NUM_DEST];

    logic                   done_q, tvalid_q, tlast_q;
    logic [TDATA_WIDTH-1:0] tdata_q;
    logic [TID_WIDTH-1:0]   tid_q;
    logic [TDEST_WIDTH-1:0] tdest_q;

    axis_tg_lfsr #(
        .WIDTH     (LOAD_LFSR_WIDTH),
        .OUT_WIDTH (LOAD_LFSR_WIDTH),
        .TAPS      (LOAD_LFSR_TAPS),
        .SEED      (LOAD_SEED)
    ) u_load_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (active),
        .value (load_state)
    );

    // Steps once per loaded flit; the pre-step value is the new flit's tdest.
    axis_tg_lfsr #(
        .WIDTH     (DEST_LFSR_WIDTH),
        .OUT_WIDTH (TDEST_WIDTH),
        .TAPS      (DEST_LFSR_TAPS),
        .SEED      (DEST_SEED)
    ) u_dest_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_flit),
        .value (new_dest)
    );

    always_comb begin
        active  = start & ~done_q & (generated_q < num_packets);
        inj_evt = active & (load_state < load);
        hs      = tvalid_q & axis_out_tready;

        backlog_inc = backlog_q;
        if (inj_evt && (backlog_q != '1)) begin
            backlog_inc = backlog_q + CNT_ONE;
        end

        // Refill the output register in the same cycle it drains; tready only
        // reaches registered state, never tvalid combinationally.
        load_flit = (~tvalid_q | hs) & (backlog_inc != '0);

        for (int i = 0; i < NUM_DEST; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (hs) begin
            cnt_d[tdest_q] = cnt_q[tdest_q] + CNT_ONE;
        end
        total_d = total_q + (hs ? CNT_ONE : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            backlog_q   <= '0;
            generated_q <= '0;
            total_q     <= '0;
            done_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tid_q       <= '0;
            tdest_q     <= '0;
            tlast_q     <= 1'b0;
            for (int i = 0; i < NUM_DEST; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            backlog_q   <= backlog_inc - (load_flit ? CNT_ONE : '0);
            generated_q <= generated_q + (inj_evt ? CNT_ONE : '0);
            total_q     <= total_d;
            done_q      <= done_q | (total_d == num_packets);
            for (int i = 0; i < NUM_DEST; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (load_flit) begin
                tvalid_q <= 1'b1;
                tdest_q  <= new_dest;
                tid_q    <= TID;
                tlast_q  <= 1'b1;
                // Sequence number includes a same-cycle handshake so it never repeats.
                tdata_q  <= {ticks, HALF'(cnt_d[new_dest])};
            end else if (hs) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_DEST; g++) begin : g_sent
        assign sent_packets[g*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[g];
    end

    assign done            = done_q;
    assign axis_out_tvalid = tvalid_q;
    assign axis_out_tdata  = tdata_q;
    assign axis_out_tlast  = tlast_q;
    assign axis_out_tid    = tid_q;
    assign axis_out_tdest  = tdest_q;

endmodule

// File: tb/tb_axis_tg.sv
module tb_axis_tg;

    localparam int NDEST = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] load = '0;
    logic [15:0] num_packets = '0;
    logic [15:0] ticks = '0;
    logic        start = 1'b0;
    logic        tready = 1'b0;
    logic        done, tvalid, tlast;
    logic [63:0] sent_packets;
    logic [31:0] tdata;
    logic [1:0]  tid, tdest;

    axis_tg #(
        .TID (2'd2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load            (load),
        .num_packets     (num_packets),
        .start           (start),
        .ticks           (ticks),
        .done            (done),
        .sent_packets    (sent_packets),
        .axis_out_tvalid (tvalid),
        .axis_out_tready (tready),
        .axis_out_tdata  (tdata),
        .axis_out_tlast  (tlast),
        .axis_out_tid    (tid),
        .axis_out_tdest  (tdest)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: event count vs accepted count; flit order follows the dest LFSR.
    logic [15:0] m_inj;
    logic [63:0] m_dst;
    int          m_gen, m_acc;
    bit          m_done, m_valid;
    int          m_sent [NDEST];

    bit          prev_stall;
    logic [31:0] prev_tdata;
    logic [1:0]  prev_tdest;
    logic [15:0] prev_ticks;
    int          cyc = 0, rel_cyc, hs_cnt, valid_cnt, last_hs_cyc;
    int          hs_log[$];
    int          run_a[$];

    function automatic logic [15:0] inj_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [63:0] dst_next(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        tready = 1'b0;
        @(negedge clk);
        check("rst_tvalid", tvalid, 0);
        check("rst_done", done, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tdest", tdest, 0);
        check("rst_tid", tid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_sent", sent_packets, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_inj = 16'h1;
        m_dst = 64'h1;
        m_gen = 0;
        m_acc = 0;
        m_done = 1'b0;
        m_valid = 1'b0;
        for (int i = 0; i < NDEST; i++) m_sent[i] = 0;
        prev_stall = 1'b0;
        prev_ticks = ticks;
        rel_cyc = 0;
        hs_cnt = 0;
        valid_cnt = 0;
        last_hs_cyc = -1;
        hs_log.delete();
    endtask

    // One clock cycle: called at a negedge with this cycle's inputs already driven.
    task automatic step();
        bit          active, ev;
        int          d;
        logic [63:0] exp_sent;
        check("done", done, m_done);
        check("tvalid", tvalid, m_valid);
        for (int i = 0; i < NDEST; i++) exp_sent[i*16 +: 16] = 16'(m_sent[i]);
        check("sent_packets", sent_packets, exp_sent);
        if (tvalid === 1'b1) begin
            valid_cnt++;
            check("tid", tid, 2);
            check("tlast", tlast, 1);
            if (prev_stall) begin
                check("stall_tdata", tdata, prev_tdata);
                check("stall_tdest", tdest, prev_tdest);
            end else begin
                check("tdata_ticks", tdata[31:16], prev_ticks);
            end
        end
        if (tvalid === 1'b1 && tready === 1'b1) begin
            hs_cnt++;
            hs_log.push_back(rel_cyc);
            last_hs_cyc = rel_cyc;
        end
        // Advance the model across the coming edge.
        active = start && !m_done && (m_gen < int'(num_packets));
        ev = active && (m_inj < load);
        if (active) m_inj = inj_next(m_inj);
        if (ev) m_gen++;
        if (m_valid && tready === 1'b1) begin
            d = int'(m_dst[1:0]);
            check("hs_tdest", tdest, d);
            check("hs_seq", tdata[15:0], m_sent[d] & 16'hFFFF);
            m_sent[d] = (m_sent[d] + 1) & 16'hFFFF;
            m_dst = dst_next(m_dst);
            m_acc++;
        end
        if (m_acc == int'(num_packets)) m_done = 1'b1;
        m_valid = (m_gen - m_acc) > 0;
        prev_stall = (tvalid === 1'b1) && (tready !== 1'b1);
        prev_tdata = tdata;
        prev_tdest = tdest;
        prev_ticks = ticks;
        @(negedge clk);
        cyc++;
        rel_cyc++;
        ticks = 16'(cyc * 3);
    endtask

    task automatic run_until_done(input int bound, input int rdy_pct, input bit toggle_start,
                                  input string tag);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            tready = ($urandom_range(99) < rdy_pct);
            if (toggle_start && (n % 37 == 36)) start = ~start;
            step();
            n++;
        end
        check({tag, "_done_reached"}, done, 1);
    endtask

    function automatic int sent_sum();
        int s = 0;
        for (int i = 0; i < NDEST; i++) s += int'(sent_packets[i*16 +: 16]);
        return s;
    endfunction

    initial begin
        int hs0;

        // Full load, always ready: 16 flits, done right after the last handshake.
        apply_reset();
        load = 16'hFFFF; num_packets = 16; start = 1'b1;
        run_until_done(200, 100, 1'b0, "s1");
        check("s1_hs_count", hs_cnt, 16);
        check("s1_sent_sum", sent_sum(), 16);
        check("s1_done_timing", rel_cyc, last_hs_cyc + 1);
        run_a = hs_log;

        // num_packets = 0: done one cycle after release, no traffic.
        apply_reset();
        load = 16'hFFFF; num_packets = 0; start = 1'b1; tready = 1'b1;
        repeat (4) step();
        check("s0_no_valid", valid_cnt, 0);

        // load = 0: never injects.
        apply_reset();
        load = 16'h0; num_packets = 16; start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tready = $urandom_range(1);
            step();
        end
        check("s2_no_valid", valid_cnt, 0);
        check("s2_not_done", done, 0);

        // Quarter load, 50% ready.
        apply_reset();
        load = 16'h4000; num_packets = 1024; start = 1'b1;
        run_until_done(20000, 50, 1'b0, "s3");
        check("s3_hs_count", hs_cnt, 1024);
        check("s3_sent_sum", sent_sum(), 1024);
        check("s3_rate_window", (rel_cyc >= 3300 && rel_cyc <= 5000), 1);

        // Long stall, then backlog drains one flit per cycle.
        apply_reset();
        load = 16'hFFFF; num_packets = 300; start = 1'b1; tready = 1'b0;
        repeat (100) step();
        check("s4_no_hs_in_stall", hs_cnt, 0);
        tready = 1'b1;
        hs0 = hs_cnt;
        repeat (100) step();
        check("s4_drain_rate", hs_cnt - hs0, 100);
        run_until_done(1000, 100, 1'b0, "s4");
        check("s4_hs_count", hs_cnt, 300);

        // start toggling: halts and resumes injection, backlog still drains.
        apply_reset();
        load = 16'h8000; num_packets = 64; start = 1'b1;
        run_until_done(5000, 70, 1'b1, "s5");
        check("s5_hs_count", hs_cnt, 64);

        // Reset mid-stream, then the first run must replay exactly.
        apply_reset();
        load = 16'hFFFF; num_packets = 16; start = 1'b1; tready = 1'b1;
        repeat (8) step();
        check("s6_midstream_valid", tvalid, 1);
        apply_reset();
        load = 16'hFFFF; num_packets = 16; start = 1'b1;
        run_until_done(200, 100, 1'b0, "s6");
        check("s6_replay_len", hs_log.size(), run_a.size());
        for (int i = 0; i < hs_log.size() && i < run_a.size(); i++) begin
            check("s6_replay_cycle", hs_log[i], run_a[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_tg.md
AXIS_TG -- requirements
Module: axis_tg

Interface
REQ-001 Parameter DEST_SEED, 64-bit, default 64'h1: initial state of the destination LFSR; a value of 0 SHALL be replaced by 1.
REQ-002 Parameter LOAD_SEED, 16-bit, default 16'h1: initial state of the injection LFSR; a value of 0 SHALL be replaced by 1.
REQ-003 Parameter COUNT_WIDTH, default 16: width of all packet counters.
REQ-004 Parameter TID, default 0: source identifier driven on tid.
REQ-005 Parameters TDATA_WIDTH default 32 (even, >=8), TDEST_WIDTH default 2, TID_WIDTH default 2: AXIS field widths.
REQ-006 clk  in  1  clock; reset rst_n, synchronous, active-low; clock clk.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 load  in  16  injection threshold; per-cycle injection probability = load/65536.
REQ-009 num_packets  in  COUNT_WIDTH  total packets to send.
REQ-010 start  in  1  level enable for generation.
REQ-011 ticks  in  TDATA_WIDTH/2  free-running timestamp.
REQ-012 done  out  1  all num_packets accepted downstream.
REQ-013 sent_packets  out  [2**TDEST_WIDTH] x COUNT_WIDTH  accepted-packet count per destination.
REQ-014 axis_out_tvalid/tready/tdata/tlast/tid/tdest  out/in/out/out/out/out  1/1/TDATA_WIDTH/1/TID_WIDTH/TDEST_WIDTH  AXI-Stream master.

Function
REQ-015 Active = start & ~done & (generated < num_packets); injection LFSR SHALL step once per clk only while active.
REQ-016 Injection LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting left with the feedback entering bit 0; an injection event SHALL occur in an active cycle when the LFSR state (pre-step) < load; load=0 never injects; load=16'hFFFF injects on every cycle except state 16'hFFFF.
REQ-017 Each event SHALL increment a backlog counter (COUNT_WIDTH, saturating); generated SHALL count events and cap at num_packets.
REQ-018 One-entry output register: when empty, or when it is emptied by a handshake this cycle, and backlog (including this cycle's event) > 0, a new flit SHALL be loaded and backlog decremented, in the same cycle.
REQ-019 Flit contents: tdest = low TDEST_WIDTH bits of destination LFSR (64-bit, taps 64,63,61,60), which SHALL step once per loaded flit; tid = TID; tlast = 1 (single-flit packets); tdata[TDATA_WIDTH-1:TDATA_WIDTH/2] = ticks at load time; tdata[TDATA_WIDTH/2-1:0] = sent_packets[tdest] at load time, truncated.
REQ-020 tvalid SHALL stay high and payload stable until tready; no combinational tready->tvalid path.
REQ-021 On handshake (tvalid & tready), sent_packets[tdest] and total_sent SHALL increment by 1; wrap-around modulo 2**COUNT_WIDTH.
REQ-022 done SHALL assert the cycle after total_sent reaches num_packets and remain high until reset; num_packets=0 SHALL assert done one cycle after reset release with no traffic.
REQ-023 Deasserting start SHALL halt new events; backlog and an in-flight flit SHALL still drain; reasserting start resumes.
REQ-024 Backpressure never loses events: events during stall accumulate in backlog.

Reset
REQ-025 Reset SHALL clear tvalid, done, backlog, generated, total_sent, all sent_packets; tdata/tdest/tid/tlast SHALL be 0; LFSRs SHALL reload their seeds.
REQ-026 Reset mid-transfer SHALL drop the pending flit with no handshake counted.

Structure
REQ-027 Shared package: LFSR tap constants and a seed-fixup function (0 -> 1).
REQ-028 One sub-module natural: axis_tg_lfsr (parameterised width/taps/seed, step enable).

Verification
REQ-029 load=16'hFFFF, num_packets=16, tready=1, start=1 -> 16 flits accepted, sum of sent_packets=16, done high the cycle after the 16th handshake.
REQ-030 load=0, start=1 for 1000 cycles -> tvalid never asserts, done stays 0.
REQ-031 load=16'h4000, num_packets=1024, random tready 50% -> exactly 1024 handshakes, payload stable across every stall, 1024*65536/load scaling gives average injection approx 0.25/cycle.
REQ-032 tready=0 for 100 cycles at load=16'hFFFF -> tvalid held, payload unchanged; backlog drains at 1 flit/cycle after tready=1.
REQ-033 Every accepted flit: tid=TID, tlast=1, tdata low half = per-destination sequence 0,1,2,... with no gaps.
REQ-034 rst_n low mid-stream -> next cycle tvalid=0, counters 0; after release sequence restarts identically to the first run (seed-deterministic).
